// File: rtl/score_board_pkg.sv
// Shared definitions for the score/HUD stage: display widths, glyph geometry,
// game-phase encodings and the saturating BCD adder.
package score_board_pkg;

    localparam int H_DISP_LEN      = 10;
    localparam int V_DISP_LEN      = 10;
    localparam int COLOR_RGB_DEPTH = 12;

    localparam int HUD_GLYPH_W = 8;
    localparam int HUD_GLYPH_H = 16;
    localparam int HUD_CELLS   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef struct packed {
        logic [COLOR_RGB_DEPTH-1:0] rgb;
        logic                       alpha;
    } hud_pix_t;

    // Four-digit BCD add of a single-digit increment; any carry out of digit 3
    // clamps the result to 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] p);
        logic [4:0]  d;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {4'b0, c} + ((i == 0) ? {1'b0, p} : 5'd0);
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return c ? 16'h9999 : r;
    endfunction

endpackage

// File: rtl/score_board_digit_font.sv
// 8x16 seven-segment style font ROM for digits 0..9; MSB is the leftmost pixel.
// Codes above 9 render blank.
module digit_font (
    input  logic [3:0] digit,
    input  logic [3:0] row,
    output logic [7:0] bits
);
    logic [6:0] seg;  // {a,b,c,d,e,f,g}

    always_comb begin
        seg = 7'b0;
        case (digit)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = 7'b0;
        endcase
    end

    // Rows 2/8/13 carry the horizontal bars; the rows between carry the verticals.
    always_comb begin
        bits = 8'h00;
        case (row)
            4'd2:                             bits = seg[6] ? 8'h7E : 8'h00;
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7:     bits = (seg[1] ? 8'h40 : 8'h00) | (seg[5] ? 8'h02 : 8'h00);
            4'd8:                             bits = seg[0] ? 8'h7E : 8'h00;
            4'd9, 4'd10, 4'd11, 4'd12:        bits = (seg[2] ? 8'h40 : 8'h00) | (seg[4] ? 8'h02 : 8'h00);
            4'd13:                            bits = seg[3] ? 8'h7E : 8'h00;
            default:                          bits = 8'h00;
        endcase
    end
endmodule

// File: rtl/score_board.sv
// Game-status stage: latches per-frame crash events, runs the IDLE/PLAY/OVER
// phase machine with BCD score and lives, and renders them as a HUD overlay.
module score_board
    import score_board_pkg::*;
#(
    parameter int                         LIVES_INIT    = 3,
    parameter int                         POINTS        = 1,
    parameter int                         INVULN_FRAMES = 120,
    parameter int                         HUD_X0        = 8,
    parameter int                         HUD_Y0        = 8,
    parameter logic [COLOR_RGB_DEPTH-1:0] HUD_RGB       = 12'hFFF
) (
    input  logic                       clk_vga,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       v_sync_i,
    input  logic [H_DISP_LEN-1:0]      req_x_addr_i,
    input  logic [V_DISP_LEN-1:0]      req_y_addr_i,
    input  logic                       crash_enemy_bullet_i,
    input  logic                       crash_me_enemy_i,
    input  logic                       start_i,
    output logic                       gamestart_o,
    output logic                       gameover_o,
    output logic [15:0]                score_bcd_o,
    output logic [3:0]                 lives_o,
    output logic [COLOR_RGB_DEPTH-1:0] vga_rgb_o,
    output logic                       vga_alpha_o
);
    localparam int IW     = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam int HUD_X1 = HUD_X0 + HUD_CELLS * HUD_GLYPH_W;
    localparam int HUD_Y1 = HUD_Y0 + HUD_GLYPH_H;

    state_e        state, state_nxt;
    logic [15:0]   score, score_nxt;
    logic [3:0]    lives, lives_nxt;
    logic [IW-1:0] inv, inv_nxt;
    logic          start_pls;
    logic          vs_q, frame_tick, hit_e, hit_m;

    assign frame_tick = vs_q & ~v_sync_i;

    always_ff @(posedge clk_vga) begin
        if (!rst) begin
            state       <= IDLE;
            score       <= '0;
            lives       <= 4'(LIVES_INIT);
            inv         <= '0;
            vs_q        <= 1'b0;
            hit_e       <= 1'b0;
            hit_m       <= 1'b0;
            gamestart_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            score       <= score_nxt;
            lives       <= lives_nxt;
            inv         <= inv_nxt;
            vs_q        <= v_sync_i;
            gamestart_o <= start_pls;
            // One event per flag per frame no matter how many pixels overlap.
            if (frame_tick || start_pls) begin
                hit_e <= 1'b0;
                hit_m <= 1'b0;
            end else if (state == PLAY) begin
                hit_e <= hit_e | crash_enemy_bullet_i;
                hit_m <= hit_m | crash_me_enemy_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        score_nxt = score;
        lives_nxt = lives;
        inv_nxt   = inv;
        start_pls = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start_i) begin
                    score_nxt = '0;
                    lives_nxt = 4'(LIVES_INIT);
                    inv_nxt   = '0;
                    start_pls = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (hit_e) score_nxt = bcd_add(score, 4'(POINTS));
                    if (hit_m && inv == '0) begin
                        lives_nxt = lives - 4'd1;
                        inv_nxt   = IW'(INVULN_FRAMES);
                        if (lives == 4'd1) state_nxt = OVER;
                    end else if (inv != '0) begin
                        inv_nxt = inv - IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gameover_o  = (state == OVER);
    assign score_bcd_o = score;
    assign lives_o     = lives;

    // Overlay: offsets are only used inside the region, so truncation is safe.
    logic       in_reg, blank;
    logic [5:0] dx;
    logic [3:0] dy, digit;
    logic [7:0] font_bits;
    hud_pix_t   pix, pix_q;

    assign in_reg = (req_x_addr_i >= H_DISP_LEN'(HUD_X0)) && (req_x_addr_i < H_DISP_LEN'(HUD_X1)) &&
                    (req_y_addr_i >= V_DISP_LEN'(HUD_Y0)) && (req_y_addr_i < V_DISP_LEN'(HUD_Y1));
    assign dx = 6'(req_x_addr_i - H_DISP_LEN'(HUD_X0));
    assign dy = 4'(req_y_addr_i - V_DISP_LEN'(HUD_Y0));

    always_comb begin
        blank = 1'b0;
        digit = 4'd0;
        case (dx[5:3])
            3'd0:    digit = score[15:12];
            3'd1:    digit = score[11:8];
            3'd2:    digit = score[7:4];
            3'd3:    digit = score[3:0];
            3'd5:    digit = lives;
            default: blank = 1'b1;
        endcase
    end

    digit_font u_font (
        .digit (digit),
        .row   (dy),
        .bits  (font_bits)
    );

    always_comb begin
        pix.alpha = en_i && in_reg && !blank && font_bits[3'd7 - dx[2:0]];
        pix.rgb   = pix.alpha ? HUD_RGB : '0;
    end

    always_ff @(posedge clk_vga) begin
        if (!rst) pix_q <= '0;
        else      pix_q <= pix;
    end

    assign vga_rgb_o   = pix_q.rgb;
    assign vga_alpha_o = pix_q.alpha;
endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board: overlay vector table plus hand-written
// frame sequences for scoring, invulnerability, game over and restart.
module tb_score_board;
    logic        clk = 1'b0;
    logic        rst, en, vs, ce, cm, start;
    logic [9:0]  rx, ry;
    logic        gstart, gover, alpha;
    logic [15:0] score;
    logic [3:0]  lives;
    logic [11:0] rgb;

    int total = 0;
    int passed = 0;

    score_board dut (
        .clk_vga(clk), .rst(rst), .en_i(en), .v_sync_i(vs),
        .req_x_addr_i(rx), .req_y_addr_i(ry),
        .crash_enemy_bullet_i(ce), .crash_me_enemy_i(cm), .start_i(start),
        .gamestart_o(gstart), .gameover_o(gover), .score_bcd_o(score),
        .lives_o(lives), .vga_rgb_o(rgb), .vga_alpha_o(alpha)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        en;
        logic        alpha;
        logic [11:0] rgb;
    } vec_t;

    vec_t       vecs[136];
    logic [7:0] three[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One frame: crashes held for 'hold' cycles, then a v_sync falling edge.
    task automatic frame(input logic e, input logic m, input int hold);
        ce = e; cm = m;
        repeat (hold) @(posedge clk);
        #1 ce = 1'b0; cm = 1'b0; vs = 1'b0;
        @(posedge clk);
        #1 vs = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input logic e, input logic m, input int n);
        for (int i = 0; i < n; i++) frame(e, m, 1);
    endtask

    task automatic start_game(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_gamestart_hi"}, gstart, 1'b1);
        chk({tag, "_score0"}, score, 16'h0000);
        chk({tag, "_lives3"}, lives, 4'd3);
        chk({tag, "_gameover0"}, gover, 1'b0);
        @(posedge clk);
        #1 chk({tag, "_gamestart_lo"}, gstart, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b0; en = 1'b0; vs = 1'b1; ce = 1'b0; cm = 1'b0; start = 1'b0;
        rx = '0; ry = '0;
        three[0] = 8'h00; three[1] = 8'h00; three[2] = 8'h7E;
        for (int r = 3; r <= 7; r++) three[r] = 8'h02;
        three[8] = 8'h7E;
        for (int r = 9; r <= 12; r++) three[r] = 8'h02;
        three[13] = 8'h7E; three[14] = 8'h00; three[15] = 8'h00;

        n = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) begin
                vecs[n] = '{10'(48 + c), 10'(8 + r), 1'b1, three[r][7-c],
                            three[r][7-c] ? 12'hFFF : 12'h000};
                n++;
            end
        vecs[n++] = '{10'd40, 10'd10, 1'b1, 1'b0, 12'h000};  // blank cell 4
        vecs[n++] = '{10'd49, 10'd10, 1'b0, 1'b0, 12'h000};  // en off over a lit pixel
        vecs[n++] = '{10'd7,  10'd10, 1'b1, 1'b0, 12'h000};  // one left of region
        vecs[n++] = '{10'd56, 10'd10, 1'b1, 1'b0, 12'h000};  // one right of region
        vecs[n++] = '{10'd9,  10'd10, 1'b1, 1'b1, 12'hFFF};  // score digit '0' top bar
        vecs[n++] = '{10'd8,  10'd10, 1'b1, 1'b0, 12'h000};  // '0' leftmost column
        vecs[n++] = '{10'd9,  10'd24, 1'b1, 1'b0, 12'h000};  // one below region
        vecs[n++] = '{10'd9,  10'd7,  1'b1, 1'b0, 12'h000};  // one above region

        repeat (3) @(posedge clk);
        #1;
        chk("rst_score", score, 16'h0000);
        chk("rst_lives", lives, 4'd3);
        chk("rst_gamestart", gstart, 1'b0);
        chk("rst_gameover", gover, 1'b0);
        chk("rst_alpha", alpha, 1'b0);
        chk("rst_rgb", rgb, 12'h000);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Overlay in IDLE: lives=3, score=0000.
        for (int i = 0; i < 136; i++) begin
            rx = vecs[i].x; ry = vecs[i].y; en = vecs[i].en;
            @(posedge clk);
            #1;
            chk($sformatf("pix_alpha[%0d]", i), alpha, vecs[i].alpha);
            chk($sformatf("pix_rgb[%0d]", i), rgb, vecs[i].rgb);
        end
        en = 1'b0; rx = '0; ry = '0;
        @(posedge clk);
        #1 chk("pix_idle_alpha", alpha, 1'b0);

        start_game("start1");

        frame(1'b1, 1'b0, 50);
        chk("score_multi_pixel", score, 16'h0001);
        frames(1'b1, 1'b0, 2);
        chk("score_three_frames", score, 16'h0003);
        frames(1'b0, 1'b0, 2);
        chk("score_no_hit", score, 16'h0003);

        frame(1'b0, 1'b1, 20);
        chk("lives_first_hit", lives, 4'd2);
        frame(1'b0, 1'b1, 1);
        chk("lives_invuln", lives, 4'd2);
        frames(1'b0, 1'b0, 118);
        frame(1'b0, 1'b1, 1);
        chk("lives_invuln_last", lives, 4'd2);
        frame(1'b0, 1'b1, 1);
        chk("lives_second_hit", lives, 4'd1);
        frames(1'b0, 1'b0, 120);
        chk("gameover_before", gover, 1'b0);
        frame(1'b1, 1'b1, 3);
        chk("fatal_lives", lives, 4'd0);
        chk("fatal_score", score, 16'h0004);
        chk("fatal_gameover", gover, 1'b1);
        frame(1'b1, 1'b1, 5);
        chk("over_score_frozen", score, 16'h0004);
        chk("over_lives_frozen", lives, 4'd0);
        chk("over_still", gover, 1'b1);

        start_game("restart");

        frames(1'b1, 1'b0, 99);
        chk("score_0099", score, 16'h0099);
        frame(1'b1, 1'b0, 1);
        chk("score_0100", score, 16'h0100);
        frames(1'b1, 1'b0, 9899);
        chk("score_9999", score, 16'h9999);
        frame(1'b1, 1'b0, 1);
        chk("score_saturate", score, 16'h9999);
        chk("lives_untouched", lives, 4'd3);

        // Mid-game reset with a lit HUD pixel requested.
        en = 1'b1; rx = 10'd49; ry = 10'd10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_score", score, 16'h0000);
        chk("midrst_lives", lives, 4'd3);
        chk("midrst_alpha", alpha, 1'b0);
        chk("midrst_gameover", gover, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("postrst_alpha", alpha, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
